// File: rtl/sii_l2t_trk_pkg.sv
// Shared types, defaults and helpers for the SII->L2T request tracker.
package sii_l2t_trk_pkg;

    localparam int TRK_DEF_NUM_CH     = 8;
    localparam int TRK_DEF_REQ_W      = 32;
    localparam int TRK_DEF_HDR_CYCLES = 2;
    localparam int TRK_DEF_GAP_CYCLES = 3;
    localparam int TRK_DEF_IQ_DEPTH   = 16;

    typedef enum logic [1:0] {
        TRK_IDLE = 2'b00,
        TRK_HDR  = 2'b01,
        TRK_GAP  = 2'b10
    } trk_state_e;

    // Width of a phase counter that must count 0 .. cycles-1.
    function automatic int trk_phase_w(input int cycles);
        return (cycles <= 1) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/sii_l2t_chan_trk.sv
// One SII->L2T tag channel: request FSM, header capture, input-queue occupancy and sticky errors.
// Optional statistics outputs (req_total, occ_max) are present when SII_L2T_TRK_STATS_EN is defined.
module sii_l2t_chan_trk
    import sii_l2t_trk_pkg::*;
#(
    parameter int REQ_W      = TRK_DEF_REQ_W,
    parameter int HDR_CYCLES = TRK_DEF_HDR_CYCLES,
    parameter int GAP_CYCLES = TRK_DEF_GAP_CYCLES,
    parameter int IQ_DEPTH   = TRK_DEF_IQ_DEPTH,
    parameter int CNT_W      = $clog2(IQ_DEPTH + 1)
) (
    input  logic                        iol2clk,
    input  logic                        rst_l,
    input  logic                        trk_en,
    input  logic                        err_clr,
    input  logic [REQ_W-1:0]            req,
    input  logic                        req_vld,
    input  logic                        iq_dequeue,
    output logic                        hdr_vld,
    output logic [HDR_CYCLES*REQ_W-1:0] hdr_data,
    output logic [CNT_W-1:0]            outst_cnt,
    output logic                        err_proto,
    output logic                        err_ovf,
    output logic                        err_unf
`ifdef SII_L2T_TRK_STATS_EN
    ,
    output logic [31:0]                 req_total,
    output logic [CNT_W-1:0]            occ_max
`endif
);

    localparam int PH_W = trk_phase_w((HDR_CYCLES > GAP_CYCLES) ? HDR_CYCLES : GAP_CYCLES);
    localparam logic [PH_W-1:0]  HDR_LAST = PH_W'(HDR_CYCLES - 1);
    localparam logic [PH_W-1:0]  GAP_LAST = PH_W'(GAP_CYCLES - 1);
    localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
    localparam logic [PH_W-1:0]  PH_ZERO  = {PH_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(IQ_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    trk_state_e                  r_state;
    trk_state_e                  w_state_nxt;
    logic [PH_W-1:0]             r_phase;
    logic [PH_W-1:0]             w_phase_nxt;
    logic                        w_acc;
    logic                        w_proto;
    logic                        w_cap_en;
    logic                        w_hdr_done;
    logic                        w_deq;
    logic                        w_ovf;
    logic                        w_unf;
    logic [CNT_W-1:0]            w_cnt_nxt;
    logic [HDR_CYCLES*REQ_W-1:0] r_shadow;
    logic [HDR_CYCLES*REQ_W-1:0] w_hdr_cap;

    // Next-state logic; the final GAP cycle may launch the next request directly.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_acc       = 1'b0;
        w_proto     = 1'b0;
        w_cap_en    = 1'b0;
        w_hdr_done  = 1'b0;
        if (!trk_en) begin
            w_state_nxt = TRK_IDLE;
            w_phase_nxt = PH_ZERO;
        end else begin
            case (r_state)
                TRK_IDLE: begin
                    if (req_vld) begin
                        w_acc       = 1'b1;
                        w_state_nxt = TRK_HDR;
                        w_phase_nxt = PH_ZERO;
                    end else begin
                        w_state_nxt = TRK_IDLE;
                    end
                end
                TRK_HDR: begin
                    w_proto  = req_vld;
                    w_cap_en = 1'b1;
                    if (r_phase == HDR_LAST) begin
                        w_hdr_done  = 1'b1;
                        w_state_nxt = TRK_GAP;
                        w_phase_nxt = PH_ZERO;
                    end else begin
                        w_phase_nxt = r_phase + PH_ONE;
                    end
                end
                TRK_GAP: begin
                    if (r_phase == GAP_LAST) begin
                        w_acc       = req_vld;
                        w_state_nxt = req_vld ? TRK_HDR : TRK_IDLE;
                        w_phase_nxt = PH_ZERO;
                    end else begin
                        w_proto     = req_vld;
                        w_phase_nxt = r_phase + PH_ONE;
                    end
                end
                default: begin
                    w_state_nxt = TRK_IDLE;
                    w_phase_nxt = PH_ZERO;
                end
            endcase
        end
    end

    // Header buffer with the word selected by the current phase replaced by the live bus.
    always_comb begin
        w_hdr_cap = r_shadow;
        for (int k = 0; k < HDR_CYCLES; k++) begin
            w_hdr_cap[k*REQ_W +: REQ_W] = (r_phase == PH_W'(k)) ? req : r_shadow[k*REQ_W +: REQ_W];
        end
    end

    // Occupancy update; simultaneous accept and dequeue cancel out.
    always_comb begin
        w_deq     = trk_en & iq_dequeue;
        w_cnt_nxt = outst_cnt;
        w_ovf     = 1'b0;
        w_unf     = 1'b0;
        if (w_acc && !w_deq) begin
            if (outst_cnt == CNT_FULL) begin
                w_ovf = 1'b1;
            end else begin
                w_cnt_nxt = outst_cnt + CNT_ONE;
            end
        end else if (w_deq && !w_acc) begin
            if (outst_cnt == CNT_ZERO) begin
                w_unf = 1'b1;
            end else begin
                w_cnt_nxt = outst_cnt - CNT_ONE;
            end
        end else begin
            w_cnt_nxt = outst_cnt;
        end
    end

    // FSM state register.
    always_ff @(posedge iol2clk) begin
        if (!rst_l) begin
            r_state <= TRK_IDLE;
            r_phase <= PH_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    // Header capture and publication.
    always_ff @(posedge iol2clk) begin
        if (!rst_l) begin
            r_shadow <= '0;
            hdr_data <= '0;
            hdr_vld  <= 1'b0;
        end else begin
            hdr_vld <= w_hdr_done;
            if (w_cap_en) begin
                r_shadow <= w_hdr_cap;
            end
            if (w_hdr_done) begin
                hdr_data <= w_hdr_cap;
            end
        end
    end

    // Occupancy counter and sticky error flags; a new error beats err_clr.
    always_ff @(posedge iol2clk) begin
        if (!rst_l) begin
            outst_cnt <= CNT_ZERO;
            err_proto <= 1'b0;
            err_ovf   <= 1'b0;
            err_unf   <= 1'b0;
        end else begin
            outst_cnt <= w_cnt_nxt;
            err_proto <= (err_proto & ~err_clr) | w_proto;
            err_ovf   <= (err_ovf & ~err_clr) | w_ovf;
            err_unf   <= (err_unf & ~err_clr) | w_unf;
        end
    end

`ifdef SII_L2T_TRK_STATS_EN
    // Saturating request total and occupancy high-water mark.
    always_ff @(posedge iol2clk) begin
        if (!rst_l || err_clr) begin
            req_total <= 32'd0;
            occ_max   <= CNT_ZERO;
        end else begin
            if (w_acc && (req_total != 32'hFFFF_FFFF)) begin
                req_total <= req_total + 32'd1;
            end
            if (w_cnt_nxt > occ_max) begin
                occ_max <= w_cnt_nxt;
            end
        end
    end
`endif

endmodule

// File: rtl/sii_l2t_req_tracker.sv
// SII->L2T inbound request tracker: NUM_CH independent channel trackers with flattened buses.
// Define SII_L2T_TRK_STATS_EN to add the req_total / occ_max statistics outputs.
module sii_l2t_req_tracker
    import sii_l2t_trk_pkg::*;
#(
    parameter int NUM_CH     = TRK_DEF_NUM_CH,
    parameter int REQ_W      = TRK_DEF_REQ_W,
    parameter int HDR_CYCLES = TRK_DEF_HDR_CYCLES,
    parameter int GAP_CYCLES = TRK_DEF_GAP_CYCLES,
    parameter int IQ_DEPTH   = TRK_DEF_IQ_DEPTH,
    localparam int CNT_W     = $clog2(IQ_DEPTH + 1)
) (
    input  logic                               iol2clk,
    input  logic                               rst_l,
    input  logic                               trk_en,
    input  logic                               err_clr,
    input  logic [NUM_CH*REQ_W-1:0]            req,
    input  logic [NUM_CH-1:0]                  req_vld,
    input  logic [NUM_CH-1:0]                  iq_dequeue,
    output logic [NUM_CH-1:0]                  hdr_vld,
    output logic [NUM_CH*HDR_CYCLES*REQ_W-1:0] hdr_data,
    output logic [NUM_CH*CNT_W-1:0]            outst_cnt,
    output logic [NUM_CH-1:0]                  err_proto,
    output logic [NUM_CH-1:0]                  err_ovf,
    output logic [NUM_CH-1:0]                  err_unf
`ifdef SII_L2T_TRK_STATS_EN
    ,
    output logic [NUM_CH*32-1:0]               req_total,
    output logic [NUM_CH*CNT_W-1:0]            occ_max
`endif
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        sii_l2t_chan_trk #(
            .REQ_W      (REQ_W),
            .HDR_CYCLES (HDR_CYCLES),
            .GAP_CYCLES (GAP_CYCLES),
            .IQ_DEPTH   (IQ_DEPTH),
            .CNT_W      (CNT_W)
        ) u_chan (
            .iol2clk    (iol2clk),
            .rst_l      (rst_l),
            .trk_en     (trk_en),
            .err_clr    (err_clr),
            .req        (req[c*REQ_W +: REQ_W]),
            .req_vld    (req_vld[c]),
            .iq_dequeue (iq_dequeue[c]),
            .hdr_vld    (hdr_vld[c]),
            .hdr_data   (hdr_data[c*HDR_CYCLES*REQ_W +: HDR_CYCLES*REQ_W]),
            .outst_cnt  (outst_cnt[c*CNT_W +: CNT_W]),
            .err_proto  (err_proto[c]),
            .err_ovf    (err_ovf[c]),
            .err_unf    (err_unf[c])
`ifdef SII_L2T_TRK_STATS_EN
            ,
            .req_total  (req_total[c*32 +: 32]),
            .occ_max    (occ_max[c*CNT_W +: CNT_W])
`endif
        );
    end

endmodule

// File: tb/tb_sii_l2t_req_tracker.sv
// Self-checking bench for sii_l2t_req_tracker: directed scenarios plus randomized traffic vs a request-age model.
// Statistics checks are compiled in when SII_L2T_TRK_STATS_EN is defined.
module tb_sii_l2t_req_tracker;

    localparam int NUM_CH = 8;
    localparam int REQ_W  = 32;
    localparam int HDR    = 2;
    localparam int GAP    = 3;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int NONE   = -1000;

    logic                        iol2clk = 1'b0;
    logic                        rst_l;
    logic                        trk_en;
    logic                        err_clr;
    logic [NUM_CH*REQ_W-1:0]     req;
    logic [NUM_CH-1:0]           req_vld;
    logic [NUM_CH-1:0]           iq_dequeue;
    logic [NUM_CH-1:0]           hdr_vld;
    logic [NUM_CH*HDR*REQ_W-1:0] hdr_data;
    logic [NUM_CH*CW-1:0]        outst_cnt;
    logic [NUM_CH-1:0]           err_proto;
    logic [NUM_CH-1:0]           err_ovf;
    logic [NUM_CH-1:0]           err_unf;
`ifdef SII_L2T_TRK_STATS_EN
    logic [NUM_CH*32-1:0]        req_total;
    logic [NUM_CH*CW-1:0]        occ_max;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: request age since last acceptance drives everything.
    int              m_cnt  [NUM_CH];
    int              m_last [NUM_CH];
    bit              m_proto[NUM_CH];
    bit              m_ovf  [NUM_CH];
    bit              m_unf  [NUM_CH];
    bit              m_hv   [NUM_CH];
    logic [REQ_W-1:0] m_cap [NUM_CH][HDR];
    logic [REQ_W-1:0] m_hdr [NUM_CH][HDR];
    longint          m_total[NUM_CH];
    int              m_omax [NUM_CH];
    int              edge_n = 0;

    sii_l2t_req_tracker #(
        .NUM_CH(NUM_CH), .REQ_W(REQ_W), .HDR_CYCLES(HDR), .GAP_CYCLES(GAP), .IQ_DEPTH(DEPTH)
    ) dut (
        .iol2clk    (iol2clk),
        .rst_l      (rst_l),
        .trk_en     (trk_en),
        .err_clr    (err_clr),
        .req        (req),
        .req_vld    (req_vld),
        .iq_dequeue (iq_dequeue),
        .hdr_vld    (hdr_vld),
        .hdr_data   (hdr_data),
        .outst_cnt  (outst_cnt),
        .err_proto  (err_proto),
        .err_ovf    (err_ovf),
        .err_unf    (err_unf)
`ifdef SII_L2T_TRK_STATS_EN
        ,
        .req_total  (req_total),
        .occ_max    (occ_max)
`endif
    );

    always #5 iol2clk = ~iol2clk;

    task automatic model_update();
        edge_n++;
        for (int c = 0; c < NUM_CH; c++) begin
            bit acc = 1'b0, pe = 1'b0, oe = 1'b0, ue = 1'b0, hv = 1'b0;
            bit deq = iq_dequeue[c];
            int age;
            if (!rst_l) begin
                m_cnt[c] = 0; m_last[c] = NONE; m_proto[c] = 0; m_ovf[c] = 0; m_unf[c] = 0;
                m_hv[c] = 0; m_total[c] = 0; m_omax[c] = 0;
                for (int k = 0; k < HDR; k++) begin m_cap[c][k] = '0; m_hdr[c][k] = '0; end
            end else begin
                if (!trk_en) begin
                    m_last[c] = NONE;
                    deq = 1'b0;
                end else begin
                    age = edge_n - m_last[c];
                    if (age >= 1 && age <= HDR) m_cap[c][age-1] = req[c*REQ_W +: REQ_W];
                    if (age == HDR) begin
                        hv = 1'b1;
                        for (int k = 0; k < HDR; k++) m_hdr[c][k] = m_cap[c][k];
                    end
                    if (req_vld[c]) begin
                        if (age >= HDR + GAP) acc = 1'b1; else pe = 1'b1;
                    end
                    if (acc) m_last[c] = edge_n;
                end
                if (acc && !deq) begin
                    if (m_cnt[c] == DEPTH) oe = 1'b1; else m_cnt[c]++;
                end else if (deq && !acc) begin
                    if (m_cnt[c] == 0) ue = 1'b1; else m_cnt[c]--;
                end
                m_proto[c] = (m_proto[c] && !err_clr) || pe;
                m_ovf[c]   = (m_ovf[c] && !err_clr) || oe;
                m_unf[c]   = (m_unf[c] && !err_clr) || ue;
                m_hv[c]    = hv;
                if (err_clr) begin
                    m_total[c] = 0;
                    m_omax[c]  = 0;
                end else begin
                    if (acc && m_total[c] < 64'hFFFF_FFFF) m_total[c]++;
                    if (m_cnt[c] > m_omax[c]) m_omax[c] = m_cnt[c];
                end
            end
        end
    endtask

    task automatic cycle();
        model_update();
        @(posedge iol2clk);
        #1;
    endtask

    task automatic set_idle();
        rst_l = 1'b1; trk_en = 1'b1; err_clr = 1'b0; req_vld = '0; iq_dequeue = '0;
    endtask

    function automatic logic [NUM_CH-1:0] exp_bits(input int sel);
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) begin
            case (sel)
                0:       v[c] = m_hv[c];
                1:       v[c] = m_proto[c];
                2:       v[c] = m_ovf[c];
                default: v[c] = m_unf[c];
            endcase
        end
        return v;
    endfunction

    function automatic logic [NUM_CH*CW-1:0] exp_cnt(input bit use_max);
        logic [NUM_CH*CW-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c*CW +: CW] = CW'(use_max ? m_omax[c] : m_cnt[c]);
        return v;
    endfunction

    function automatic logic [NUM_CH*HDR*REQ_W-1:0] exp_hdr();
        logic [NUM_CH*HDR*REQ_W-1:0] v;
        for (int c = 0; c < NUM_CH; c++)
            for (int k = 0; k < HDR; k++) v[(c*HDR+k)*REQ_W +: REQ_W] = m_hdr[c][k];
        return v;
    endfunction

    task automatic test_reset();
        set_idle(); rst_l = 1'b0; req = '0;
        cycle(); cycle();
        n_tests++;
        if ({hdr_vld, err_proto, err_ovf, err_unf} !== 32'd0) begin
            n_fail++; $display("FAIL reset_flags: got %h required 0", {hdr_vld, err_proto, err_ovf, err_unf});
        end
        n_tests++;
        if (outst_cnt !== '0 || hdr_data !== '0) begin
            n_fail++; $display("FAIL reset_data: cnt %h hdr %h required 0", outst_cnt, hdr_data);
        end
        set_idle();
    endtask

    task automatic test_header();
        logic [NUM_CH*CW-1:0]        cnt_o;
        logic [NUM_CH*HDR*REQ_W-1:0] hdr_o;
        set_idle();
        for (int c = 0; c < NUM_CH; c++) req[c*REQ_W +: REQ_W] = $urandom;
        req_vld[3] = 1'b1; cycle();
        req_vld = '0; req[3*REQ_W +: REQ_W] = 32'hA5A5_0001; cycle();
        req[3*REQ_W +: REQ_W] = 32'h0000_BEEF; cycle();
        n_tests++;
        if (hdr_vld !== 8'h08) begin n_fail++; $display("FAIL hdr_vld_pulse: got %h required 08", hdr_vld); end
        n_tests++;
        if (hdr_data[6*REQ_W +: REQ_W] !== 32'hA5A5_0001 || hdr_data[7*REQ_W +: REQ_W] !== 32'h0000_BEEF) begin
            n_fail++; $display("FAIL hdr_words: got %h %h required a5a50001 0000beef",
                               hdr_data[6*REQ_W +: REQ_W], hdr_data[7*REQ_W +: REQ_W]);
        end
        cnt_o = outst_cnt; cnt_o[3*CW +: CW] = '0;
        hdr_o = hdr_data;  hdr_o[6*REQ_W +: 2*REQ_W] = '0;
        n_tests++;
        if (outst_cnt[3*CW +: CW] !== 3'd1 || cnt_o !== '0 || hdr_o !== '0) begin
            n_fail++; $display("FAIL hdr_isolation: cnt %h hdr_other %h required ch3=1 others 0", outst_cnt, hdr_o);
        end
        cycle();
        n_tests++;
        if (hdr_vld !== 8'h00) begin n_fail++; $display("FAIL hdr_vld_width: got %h required 00", hdr_vld); end
    endtask

    task automatic test_protocol();
        set_idle();
        req_vld[0] = 1'b1; cycle();
        req_vld[0] = 1'b0; cycle();
        req_vld[0] = 1'b1; cycle();
        n_tests++;
        if (err_proto !== 8'h01 || outst_cnt[0 +: CW] !== 3'd1) begin
            n_fail++; $display("FAIL proto_in_hdr: proto %h cnt0 %0d required 01 / 1", err_proto, outst_cnt[0 +: CW]);
        end
        req_vld[0] = 1'b0; cycle(); cycle();
        req_vld[0] = 1'b1; cycle();
        n_tests++;
        if (outst_cnt[0 +: CW] !== 3'd2 || err_ovf[0] !== 1'b0 || err_unf[0] !== 1'b0) begin
            n_fail++; $display("FAIL final_gap_accept: cnt0 %0d ovf %b unf %b required 2/0/0",
                               outst_cnt[0 +: CW], err_ovf[0], err_unf[0]);
        end
        set_idle();
        for (int i = 0; i < 6; i++) cycle();
        err_clr = 1'b1; cycle(); err_clr = 1'b0;
        n_tests++;
        if (err_proto !== 8'h00) begin n_fail++; $display("FAIL proto_clear: got %h required 00", err_proto); end
    endtask

    task automatic test_overflow();
        set_idle();
        for (int r = 0; r < 5; r++) begin
            req_vld[5] = 1'b1; cycle();
            req_vld[5] = 1'b0;
            for (int i = 0; i < 4; i++) cycle();
        end
        n_tests++;
        if (outst_cnt[5*CW +: CW] !== 3'd4 || err_ovf[5] !== 1'b1) begin
            n_fail++; $display("FAIL overflow: cnt5 %0d ovf %b required 4/1", outst_cnt[5*CW +: CW], err_ovf[5]);
        end
        err_clr = 1'b1; cycle(); err_clr = 1'b0;
        n_tests++;
        if (err_ovf[5] !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b required 0", err_ovf[5]); end
        req_vld[5] = 1'b1; iq_dequeue[5] = 1'b1; cycle(); set_idle();
        n_tests++;
        if (outst_cnt[5*CW +: CW] !== 3'd4 || err_ovf[5] !== 1'b0 || err_unf[5] !== 1'b0) begin
            n_fail++; $display("FAIL full_vld_deq: cnt5 %0d ovf %b unf %b required 4/0/0",
                               outst_cnt[5*CW +: CW], err_ovf[5], err_unf[5]);
        end
    endtask

    task automatic test_underflow();
        set_idle();
        iq_dequeue[7] = 1'b1; cycle();
        n_tests++;
        if (err_unf[7] !== 1'b1 || outst_cnt[7*CW +: CW] !== 3'd0) begin
            n_fail++; $display("FAIL underflow: unf %b cnt7 %0d required 1/0", err_unf[7], outst_cnt[7*CW +: CW]);
        end
        iq_dequeue[7] = 1'b0; err_clr = 1'b1; cycle();
        n_tests++;
        if (err_unf[7] !== 1'b0) begin n_fail++; $display("FAIL unf_clear: got %b required 0", err_unf[7]); end
        iq_dequeue[7] = 1'b1; cycle(); set_idle();
        n_tests++;
        if (err_unf[7] !== 1'b1) begin n_fail++; $display("FAIL clr_vs_new_err: got %b required 1", err_unf[7]); end
    endtask

    task automatic test_reset_enable();
        set_idle();
        req_vld[1] = 1'b1; cycle();
        req_vld[1] = 1'b0; req[1*REQ_W +: REQ_W] = 32'h1234_5678; cycle();
        rst_l = 1'b0; cycle();
        n_tests++;
        if ({hdr_vld, err_proto, err_ovf, err_unf} !== 32'd0 || outst_cnt !== '0 || hdr_data !== '0) begin
            n_fail++; $display("FAIL midpkt_reset: flags %h cnt %h required 0", {hdr_vld, err_proto, err_ovf, err_unf}, outst_cnt);
        end
        rst_l = 1'b1; cycle();
        n_tests++;
        if (hdr_vld !== 8'h00) begin n_fail++; $display("FAIL no_partial_hdr: got %h required 00", hdr_vld); end
        req_vld[1] = 1'b1; cycle(); set_idle();
        trk_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            req_vld = NUM_CH'($urandom); iq_dequeue = NUM_CH'($urandom); cycle();
            n_tests++;
            if (outst_cnt !== 24'h000008 || {hdr_vld, err_proto, err_ovf, err_unf} !== 32'd0) begin
                n_fail++; $display("FAIL disabled_hold: cnt %h flags %h required 000008 / 0",
                                   outst_cnt, {hdr_vld, err_proto, err_ovf, err_unf});
            end
        end
        set_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst_l   = ($urandom_range(0, 399) != 0);
            trk_en  = ($urandom_range(0, 49) != 0);
            err_clr = ($urandom_range(0, 39) == 0);
            for (int c = 0; c < NUM_CH; c++) begin
                req_vld[c]    = ($urandom_range(0, 9) < 4);
                iq_dequeue[c] = ($urandom_range(0, 9) < 3);
                req[c*REQ_W +: REQ_W] = $urandom;
            end
            cycle();
            n_tests++;
            if (hdr_vld !== exp_bits(0) || hdr_data !== exp_hdr()) begin
                n_fail++; $display("FAIL rnd_hdr @%0d: vld %h data %h required %h %h",
                                   i, hdr_vld, hdr_data, exp_bits(0), exp_hdr());
            end
            n_tests++;
            if (outst_cnt !== exp_cnt(1'b0)) begin
                n_fail++; $display("FAIL rnd_cnt @%0d: got %h required %h", i, outst_cnt, exp_cnt(1'b0));
            end
            n_tests++;
            if ({err_proto, err_ovf, err_unf} !== {exp_bits(1), exp_bits(2), exp_bits(3)}) begin
                n_fail++; $display("FAIL rnd_err @%0d: got %h required %h", i,
                                   {err_proto, err_ovf, err_unf}, {exp_bits(1), exp_bits(2), exp_bits(3)});
            end
`ifdef SII_L2T_TRK_STATS_EN
            n_tests++;
            if (occ_max !== exp_cnt(1'b1) || req_total[0 +: 32] !== 32'(m_total[0]) ||
                req_total[7*32 +: 32] !== 32'(m_total[7])) begin
                n_fail++; $display("FAIL rnd_stats @%0d: occ %h tot0 %0d tot7 %0d required %h %0d %0d", i,
                                   occ_max, req_total[0 +: 32], req_total[7*32 +: 32], exp_cnt(1'b1), m_total[0], m_total[7]);
            end
`endif
        end
        set_idle();
    endtask

`ifdef SII_L2T_TRK_STATS_EN
    task automatic test_stats();
        set_idle(); rst_l = 1'b0; cycle(); rst_l = 1'b1;
        for (int r = 0; r < 5; r++) begin
            if (r == 3) begin iq_dequeue[2] = 1'b1; cycle(); iq_dequeue[2] = 1'b0; end
            req_vld[2] = 1'b1; cycle(); req_vld[2] = 1'b0;
            for (int i = 0; i < 4; i++) cycle();
        end
        n_tests++;
        if (req_total[2*32 +: 32] !== 32'd5 || occ_max[2*CW +: CW] !== 3'd4) begin
            n_fail++; $display("FAIL stats_ch2: total %0d occ_max %0d required 5/4",
                               req_total[2*32 +: 32], occ_max[2*CW +: CW]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_header();
        test_protocol();
        test_overflow();
        test_underflow();
        test_reset_enable();
        test_random();
`ifdef SII_L2T_TRK_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
